sum_frame_accumulator: RTL and testbench
========================================

Name: sum_frame_accumulator

Overview:
- Stage directly downstream of the operand adder.
- Consumes the adder's sum stream over a valid/ready handshake and accumulates FRAME_LEN consecutive sums into one frame total.
- Presents the total, plus the number of sums it contains, on a registered valid/ready output toward the scoreboard/sink.
- Supports early frame close via a flush strobe.

Parameters:
- IN_W, 9, width of incoming sum (two 8-bit operands plus carry).
- ACC_W, 16, width of accumulator and out_data.
- FRAME_LEN, 4, sums per frame; legal range 1..255.
- CNT_W, 8, width of out_count; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  IN_W  sum from adder (its output data).
- in_valid  in  1  sum valid.
- in_ready  out  1  block accepts sum; registered.
- flush  in  1  single-cycle strobe; close current frame early.
- out_data  out  ACC_W  frame total; registered.
- out_count  out  CNT_W  number of sums in the presented frame; registered.
- out_ovf  out  1  accumulator saturated during the frame (see Optional Feature).
- out_valid  out  1  frame result valid; registered.
- out_ready  in  1  sink accepts result.

Behaviour:
- Reset is asynchronous, active-high: in_ready=0, out_valid=0, out_data=0, out_count=0, out_ovf=0, acc=0, cnt=0, state=INIT.
- Handshake: a transfer occurs on a rising clk edge where valid&&ready. Registered ready/valid only; no combinational path from in_valid or out_ready to any output.
- INIT: one cycle after reset deasserts; set in_ready<=1; go to ACCUM.
- ACCUM, on an input handshake:
  - next = acc + zero-extended in_data; cnt+1.
  - If cnt+1 == FRAME_LEN, or flush is high in the same cycle: out_data<=next, out_count<=cnt+1, out_valid<=1, in_ready<=0; go to SEND.
  - Otherwise acc<=next, cnt<=cnt+1.
- ACCUM, flush without a handshake:
  - If cnt>0: present acc/cnt, out_valid<=1, in_ready<=0; go to SEND.
  - If cnt==0: ignored (no empty frames).
- SEND:
  - out_data, out_count and out_ovf are held stable while out_valid && !out_ready.
  - On out_ready: out_valid<=0, acc<=0, cnt<=0, ovf<=0, in_ready<=1; go to ACCUM.
  - flush and in_valid are ignored in SEND.
- Latency: last sum accepted at edge N means out_valid is high after edge N. A new frame's first sum can be accepted the cycle after the output handshake, giving one bubble per frame (mirrors the adder's SEND->WAIT bubble).
- Arithmetic: unsigned. Default mode wraps modulo 2^ACC_W.
- FRAME_LEN==1: every accepted sum produces a frame with out_count=1.
- Reset mid-frame or mid-SEND: the partial frame is discarded and the block returns to INIT; no output is produced for it.
- in_data is sampled only on a handshake; X on in_data while in_valid=0 must not propagate into acc.

Optional Feature:
- Macro: SUM_FRAME_ACC_SAT_EN.
- Defined: the add saturates at 2^ACC_W-1. Any saturating add sets a sticky ovf flag, presented as out_ovf with the frame; ovf clears on the output handshake.
- Undefined: the add wraps, and out_ovf is tied to 0.
- Port list is identical in both builds.

Test Plan:
- Reset, then feed 1,2,3,4 with out_ready=1 -> in_ready rises 1 cycle after rst deasserts; one frame out_data=10, out_count=4; in_ready=0 while out_valid=1.
- Feed 5,6 then pulse flush alone -> frame out_data=11, out_count=2. Next, pulse flush with cnt==0 -> no output.
- Feed 7 with flush asserted on the same handshake cycle -> out_data=7, out_count=1.
- Complete a frame, hold out_ready=0 for 5 cycles while driving in_valid=1 with in_data=9 -> out_data stable; in_ready=0; no sums lost or counted. Release out_ready -> next frame starts with 9.
- IN_W=9, ACC_W=10, feed 511,511,511,511:
  - Undefined macro: out_data=1020, then 1020+... wraps to 2044 mod 1024=1020, out_ovf=0.
  - SUM_FRAME_ACC_SAT_EN defined: out_data=1023, out_ovf=1; next frame's out_ovf=0.
- Assert rst after 2 of 4 sums, then feed 1,1,1,1 -> only one frame appears, out_data=4; the partial frame is never output.

Source files
------------

// File: rtl/sum_frame_accumulator.sv
// sum_frame_accumulator: sums FRAME_LEN consecutive adder results into one
// frame total and presents it, with its sum count, on a registered
// valid/ready output. A flush strobe closes a non-empty frame early.
// Optional build macro SUM_FRAME_ACC_SAT_EN: saturating add with a sticky
// overflow flag reported on out_ovf; otherwise the add wraps and out_ovf is 0.
module sum_frame_accumulator #(
  parameter int unsigned IN_W      = 9,
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_ACCUM = 2'd1,
    S_SEND  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic [ACC_W-1:0] add_res;
  logic [CNT_W-1:0] cnt_inc;
  logic             in_hs;
  logic             frame_full;

`ifdef SUM_FRAME_ACC_SAT_EN
  logic             ovf_q, ovf_d;
  logic             out_ovf_q, out_ovf_d;
  logic [SUM_W-1:0] sum_wide;
  logic             add_ovf;

  // Saturating add: clamp to all-ones when the carry out is set.
  always_comb begin
    sum_wide = SUM_W'(acc_q) + SUM_W'(in_data);
    add_ovf  = sum_wide[ACC_W];
    add_res  = add_ovf ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  end
`else
  // Wrapping add modulo 2^ACC_W.
  always_comb begin
    add_res = acc_q + ACC_W'(in_data);
  end
`endif

  // Handshake qualifiers and frame-length detection.
  always_comb begin
    in_hs      = in_ready_q & in_valid;
    cnt_inc    = cnt_q + CNT_W'(1);
    frame_full = (cnt_inc == CNT_W'(FRAME_LEN));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
`ifdef SUM_FRAME_ACC_SAT_EN
    ovf_d       = ovf_q;
    out_ovf_d   = out_ovf_q;
`endif
    unique case (state_q)
      S_INIT: begin
        in_ready_d = 1'b1;
        state_d    = S_ACCUM;
      end
      S_ACCUM: begin
        if (in_hs) begin
          if (frame_full || flush) begin
            out_data_d  = add_res;
            out_count_d = cnt_inc;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
`ifdef SUM_FRAME_ACC_SAT_EN
            out_ovf_d   = ovf_q | add_ovf;
`endif
            state_d     = S_SEND;
          end else begin
            acc_d = add_res;
            cnt_d = cnt_inc;
`ifdef SUM_FRAME_ACC_SAT_EN
            ovf_d = ovf_q | add_ovf;
`endif
          end
        end else if (flush && (cnt_q != '0)) begin
          // Early close of a partial frame; empty frames are never emitted.
          out_data_d  = acc_q;
          out_count_d = cnt_q;
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
`ifdef SUM_FRAME_ACC_SAT_EN
          out_ovf_d   = ovf_q;
`endif
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          in_ready_d  = 1'b1;
`ifdef SUM_FRAME_ACC_SAT_EN
          ovf_d       = 1'b0;
`endif
          state_d     = S_ACCUM;
        end
      end
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        state_d     = S_INIT;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
`ifdef SUM_FRAME_ACC_SAT_EN
      ovf_q       <= 1'b0;
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
`ifdef SUM_FRAME_ACC_SAT_EN
      ovf_q       <= ovf_d;
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
`ifdef SUM_FRAME_ACC_SAT_EN
  assign out_ovf   = out_ovf_q;
`else
  assign out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_sum_frame_accumulator.sv
// Bench for sum_frame_accumulator: two instances (ACC_W=16 and ACC_W=10)
// share one stimulus stream; a frame-level reference model predicts both.
module tb_sum_frame_accumulator;

  localparam int unsigned FL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  in_data;
  logic        in_valid, flush, out_ready;

  logic        a_ready, a_valid, a_ovf;
  logic [15:0] a_data;
  logic [7:0]  a_count;
  logic        b_ready, b_valid, b_ovf;
  logic [9:0]  b_data;
  logic [7:0]  b_count;

  sum_frame_accumulator #(.IN_W(9), .ACC_W(16), .FRAME_LEN(FL), .CNT_W(8)) u16 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(a_ready),
    .flush(flush), .out_data(a_data), .out_count(a_count), .out_ovf(a_ovf),
    .out_valid(a_valid), .out_ready(out_ready));

  sum_frame_accumulator #(.IN_W(9), .ACC_W(10), .FRAME_LEN(FL), .CNT_W(8)) u10 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(b_ready),
    .flush(flush), .out_data(b_data), .out_count(b_count), .out_ovf(b_ovf),
    .out_valid(b_valid), .out_ready(out_ready));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: sums of the open frame, plus the presented result.
  int  cur_q[$];
  bit  m_init, m_ready, m_ovalid;
  int  e16, e10, ecnt;
  bit  eo16, eo10;

  typedef struct {
    bit v; int d; bit f; bit r;
    bit eir; bit eov; int edata; int ecnt;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame total from the list of accepted sums, for an accumulator of maxv.
  function automatic int fold(input int maxv, output bit ov);
    longint a = 0;
    ov = 1'b0;
    foreach (cur_q[i]) begin
      a += cur_q[i];
      if (a > maxv) begin
`ifdef SUM_FRAME_ACC_SAT_EN
        a  = maxv;
        ov = 1'b1;
`else
        a = a - (longint'(maxv) + 1);
`endif
      end
    end
    return int'(a);
  endfunction

  task automatic close_frame();
    e16  = fold(65535, eo16);
    e10  = fold(1023, eo10);
    ecnt = cur_q.size();
    cur_q.delete();
    m_ovalid = 1'b1;
    m_ready  = 1'b0;
  endtask

  task automatic model_edge(input bit v, input int d, input bit f, input bit r);
    if (m_init) begin
      m_init  = 1'b0;
      m_ready = 1'b1;
    end else if (m_ovalid) begin
      if (r) begin
        m_ovalid = 1'b0;
        m_ready  = 1'b1;
      end
    end else if (m_ready) begin
      if (v) begin
        cur_q.push_back(d);
        if (cur_q.size() == FL || f) close_frame();
      end else if (f && cur_q.size() > 0) begin
        close_frame();
      end
    end
  endtask

  task automatic model_check();
    chk("in_ready16", int'(a_ready), int'(m_ready));
    chk("in_ready10", int'(b_ready), int'(m_ready));
    chk("out_valid16", int'(a_valid), int'(m_ovalid));
    chk("out_valid10", int'(b_valid), int'(m_ovalid));
    if (m_ovalid) begin
      chk("out_data16", int'(a_data), e16);
      chk("out_data10", int'(b_data), e10);
      chk("out_count16", int'(a_count), ecnt);
      chk("out_count10", int'(b_count), ecnt);
      chk("out_ovf16", int'(a_ovf), int'(eo16));
      chk("out_ovf10", int'(b_ovf), int'(eo10));
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input bit v, input int d, input bit f, input bit r);
    in_valid  = v;
    in_data   = v ? 9'(d) : 9'($urandom);
    flush     = f;
    out_ready = r;
    @(posedge clk);
    model_edge(v, d, f, r);
    #1;
    model_check();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(a_ready), 0);
    chk({tag, "_out_valid"}, int'(a_valid), 0);
    chk({tag, "_out_data"}, int'(a_data), 0);
    chk({tag, "_out_count"}, int'(a_count), 0);
    chk({tag, "_out_ovf"}, int'(a_ovf), 0);
    chk({tag, "_out_valid10"}, int'(b_valid), 0);
  endtask

  // Asynchronous reset pulse between clock edges; model drops any frame.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur_q.delete();
    m_init   = 1'b1;
    m_ready  = 1'b0;
    m_ovalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    m_init = 1'b0; m_ready = 1'b0; m_ovalid = 1'b0;
    e16 = 0; e10 = 0; ecnt = 0; eo16 = 1'b0; eo10 = 1'b0;

    //           v  d  f  r  ir ov data cnt
    tbl[0]  = '{0, 0, 0, 1, 1, 0, 0,  0};
    tbl[1]  = '{1, 1, 0, 1, 1, 0, 0,  0};
    tbl[2]  = '{1, 2, 0, 1, 1, 0, 0,  0};
    tbl[3]  = '{1, 3, 0, 1, 1, 0, 0,  0};
    tbl[4]  = '{1, 4, 0, 1, 0, 1, 10, 4};
    tbl[5]  = '{0, 0, 0, 1, 1, 0, 0,  0};
    tbl[6]  = '{1, 5, 0, 1, 1, 0, 0,  0};
    tbl[7]  = '{1, 6, 0, 1, 1, 0, 0,  0};
    tbl[8]  = '{0, 0, 1, 1, 0, 1, 11, 2};
    tbl[9]  = '{0, 0, 0, 1, 1, 0, 0,  0};
    tbl[10] = '{0, 0, 1, 1, 1, 0, 0,  0};
    tbl[11] = '{1, 7, 1, 1, 0, 1, 7,  1};
    tbl[12] = '{0, 0, 0, 1, 1, 0, 0,  0};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    m_init = 1'b1;

    // Directed table: full frame, flush-closed frame, empty flush, flush+data.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      chk($sformatf("tbl%0d_in_ready", i), int'(a_ready), int'(tbl[i].eir));
      chk($sformatf("tbl%0d_out_valid", i), int'(a_valid), int'(tbl[i].eov));
      if (tbl[i].eov) begin
        chk($sformatf("tbl%0d_out_data", i), int'(a_data), tbl[i].edata);
        chk($sformatf("tbl%0d_out_count", i), int'(a_count), tbl[i].ecnt);
      end
    end

    // Backpressure: result held, inputs blocked, pending 9 starts next frame.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1);
    step(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 9, 0, 0);
      chk("bp_in_ready", int'(a_ready), 0);
      chk("bp_out_valid", int'(a_valid), 1);
      chk("bp_out_data", int'(a_data), 4);
      chk("bp_out_count", int'(a_count), 4);
    end
    step(1, 9, 0, 1);
    chk("bp_release_in_ready", int'(a_ready), 1);
    step(1, 9, 1, 1);
    chk("bp_next_out_data", int'(a_data), 9);
    chk("bp_next_out_count", int'(a_count), 1);
    step(0, 0, 0, 1);

    // Accumulator overflow on the 10-bit instance.
    for (int i = 0; i < 4; i++) step(1, 511, 0, 1);
`ifdef SUM_FRAME_ACC_SAT_EN
    chk("ovf_out_data10", int'(b_data), 1023);
    chk("ovf_out_ovf10", int'(b_ovf), 1);
`else
    chk("ovf_out_data10", int'(b_data), 1020);
    chk("ovf_out_ovf10", int'(b_ovf), 0);
`endif
    chk("ovf_out_data16", int'(a_data), 2044);
    step(0, 0, 0, 1);
    step(1, 1, 1, 1);
    chk("ovf_next_ovf10", int'(b_ovf), 0);
    chk("ovf_next_data10", int'(b_data), 1);
    step(0, 0, 0, 1);

    // Reset mid-frame: partial frame dropped, next frame complete.
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    do_reset();
    step(0, 0, 0, 1);
    chk("rst_init_in_ready", int'(a_ready), 1);
    for (int i = 0; i < 4; i++) begin
      chk("rst_no_stale_frame", int'(a_valid), 0);
      step(1, 1, 0, 1);
    end
    chk("rst_frame_data", int'(a_data), 4);
    chk("rst_frame_count", int'(a_count), 4);
    step(0, 0, 0, 1);

    // Reset while a result is waiting in SEND.
    for (int i = 0; i < 4; i++) step(1, 3, 0, 0);
    do_reset();
    step(0, 0, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 511)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
